sensor_conditioner: RTL and testbench
=====================================

// Module: sensor_conditioner
// PURPOSE
//  Upstream stage of the irrigation controller. Conditions the raw light (SL) and
//  soil-humidity (SH) comparator inputs before they reach the message/valve FSM.
//  - 2-flop synchroniser and per-channel debounce state machine.
//  - Produces clean levels, one-cycle edge pulses and a "valid" flag that marks
//    both channels as settled since reset.
// PARAMETERS
//  DEBOUNCE_CYCLES  500_000  consecutive stable cycles needed to accept a change (10 ms @ 50 MHz)
//  CNT_W            20       debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//  HOLDOFF_CYCLES   50_000_000  SH low dwell before a new SH rise is accepted (SH_HOLDOFF_EN only)
//  HOLD_W           26       holdoff counter width; must satisfy 2**HOLD_W > HOLDOFF_CYCLES
// PORTS
//  Clk      in   1  system clock, 50 MHz
//  reset    in   1  asynchronous, active-high reset
//  SL_raw   in   1  raw light-sensor input, asynchronous to Clk
//  SH_raw   in   1  raw humidity-sensor input, asynchronous to Clk
//  SL       out  1  debounced light level
//  SH       out  1  debounced humidity level
//  SL_rise  out  1  one-cycle pulse when SL goes 0->1
//  SL_fall  out  1  one-cycle pulse when SL goes 1->0
//  SH_rise  out  1  one-cycle pulse when SH goes 0->1
//  SH_fall  out  1  one-cycle pulse when SH goes 1->0
//  valid    out  1  both channels settled at least once since reset; sticky until reset
// BEHAVIOUR
//  - Reset: all outputs 0, sync flops 0, counters 0, both FSMs in ST_LO, valid 0.
//  - Sync: raw -> s1 -> s2. The FSMs and the settle tracking use s2 only.
//  - Per-channel FSM, with states ST_LO, PEND_HI, ST_HI and PEND_LO:
//      ST_LO:   s2=1 -> PEND_HI, cnt<=0.
//      PEND_HI: s2=0 -> ST_LO, cnt<=0 (glitch rejected, no pulse).
//               s2=1 and cnt==DEBOUNCE_CYCLES-1 -> ST_HI; out<=1; rise<=1 for one cycle.
//               Otherwise cnt<=cnt+1.
//      ST_HI / PEND_LO: mirror of the above; fall pulse on entry to ST_LO.
//  - Counter never exceeds DEBOUNCE_CYCLES-1 and never wraps. It is zeroed on
//    every state entry.
//  - Latency: a raw edge held stable appears at the output 2+DEBOUNCE_CYCLES
//    cycles after the first Clk edge that samples it. Pulses are registered and
//    coincide with the output change.
//  - Settle tracking: each channel counts cycles where its FSM is in ST_LO or ST_HI.
//    * The channel is settled once that count reaches DEBOUNCE_CYCLES.
//    * valid<=1 in the cycle both channels are settled, then holds until reset.
//    * If an input is 1 at reset, valid rises only after that channel has
//      qualified high and then stayed stable for DEBOUNCE_CYCLES more cycles.
//  - The two channels are fully independent. Simultaneous edges on SL and SH
//    may pulse in the same cycle.
//  - Reset mid-PEND: the pending change is discarded, the output returns to 0
//    and no pulse is generated.
// CONFIGURATION
//  SH_HOLDOFF_EN defined:
//    - After SH_fall, the SH channel ignores s2=1 for HOLDOFF_CYCLES cycles: it
//      stays in ST_LO with its debounce counter held at 0.
//    - Holdoff counter resets to 0; a reset during holdoff clears it.
//    - Purpose: stops the valve re-opening on soil-moisture chatter.
//    - SL is unaffected.
//  SH_HOLDOFF_EN undefined: no holdoff logic is generated; SH follows the FSM above.
// TESTING  (sim: DEBOUNCE_CYCLES=8, HOLDOFF_CYCLES=20)
//  1. reset high 3 cyc with SL_raw=SH_raw=0, then release -> all outputs 0; valid=1 at cycle 8.
//  2. SL_raw 0->1, held -> SL=1 and SL_rise=1 exactly 10 cycles later, for 1 cycle;
//     SL_fall never asserts.
//  3. SH_raw high for 5 cycles, then low -> SH stays 0; no SH_rise or SH_fall pulse.
//  4. SL_raw and SH_raw rise on the same edge -> SL_rise and SH_rise pulse in the same
//     cycle; SL=SH=1.
//  5. SH_raw=1, reset asserted 6 cycles later and released -> SH=0, no pulse; SH rises
//     only 10 cycles after release.
//  6. SH_HOLDOFF_EN: SH falls, then SH_raw=1 again 2 cycles later -> SH stays 0 until
//     holdoff ends; SH_rise arrives 20+8 cycles after SH_fall.
//     Without the macro the same stimulus gives SH_rise 10 cycles after SH_raw rises.

Source files
------------

// File: rtl/sensor_conditioner.sv
// sensor_conditioner: conditions the raw light (SL) and soil-humidity (SH)
// comparator inputs for the irrigation controller. Each channel has a 2-flop
// synchroniser and a debounce FSM. The block outputs clean levels, one-cycle
// rise/fall pulses, and a sticky "valid" flag that rises once both channels
// have settled since reset.
// Optional build macro SH_HOLDOFF_EN: after an SH fall, SH rises are ignored
// for HOLDOFF_CYCLES cycles. SL is never affected.
// Handshake note: there is no valid/ready traffic here. Outputs are plain
// registered levels and single-cycle pulses.
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int CNT_W           = 20,
  parameter int HOLDOFF_CYCLES  = 50_000_000,
  parameter int HOLD_W          = 26
) (
  input  logic Clk,
  input  logic reset,
  input  logic SL_raw,
  input  logic SH_raw,
  output logic SL,
  output logic SH,
  output logic SL_rise,
  output logic SL_fall,
  output logic SH_rise,
  output logic SH_fall,
  output logic valid
);

  // Counter widths must be able to hold the cycle counts they are compared against.
  if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_cnt_w_chk
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if ((64'd1 << HOLD_W) <= 64'(HOLDOFF_CYCLES)) begin : g_hold_w_chk
    $error("HOLD_W too narrow for HOLDOFF_CYCLES");
  end

  typedef enum logic [1:0] {ST_LO, PEND_HI, ST_HI, PEND_LO} deb_state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_FULL = CNT_W'(DEBOUNCE_CYCLES);

  // Channel index 0 is SL and channel index 1 is SH throughout.
  logic [1:0]       raw_in;
  logic [1:0]       s1, s2;
  deb_state_t       state   [2];
  logic [CNT_W-1:0] cnt     [2];
  logic [CNT_W-1:0] stl_cnt [2];
  logic [CNT_W-1:0] stl_nxt [2];
  logic [1:0]       lvl, rise, fall;
  logic [1:0]       blk;

  assign raw_in = {SH_raw, SL_raw};

  // Two-flop synchroniser for both asynchronous sensor inputs.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in;
      s2 <= s1;
    end
  end

  // Debounce FSM per channel. A level change is accepted only after s2 has
  // held the new value for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        state[ch] <= ST_LO;
        cnt[ch]   <= '0;
      end
      lvl  <= '0;
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= '0;
      fall <= '0;
      for (int ch = 0; ch < 2; ch++) begin
        unique case (state[ch])
          ST_LO: begin
            if (s2[ch] && !blk[ch]) begin
              state[ch] <= PEND_HI;
              cnt[ch]   <= '0;
            end
          end
          PEND_HI: begin
            if (!s2[ch]) begin
              state[ch] <= ST_LO;
              cnt[ch]   <= '0;
            end else if (cnt[ch] == DEB_LAST) begin
              state[ch] <= ST_HI;
              cnt[ch]   <= '0;
              lvl[ch]   <= 1'b1;
              rise[ch]  <= 1'b1;
            end else begin
              cnt[ch] <= cnt[ch] + 1'b1;
            end
          end
          ST_HI: begin
            if (!s2[ch]) begin
              state[ch] <= PEND_LO;
              cnt[ch]   <= '0;
            end
          end
          PEND_LO: begin
            if (s2[ch]) begin
              state[ch] <= ST_HI;
              cnt[ch]   <= '0;
            end else if (cnt[ch] == DEB_LAST) begin
              state[ch] <= ST_LO;
              cnt[ch]   <= '0;
              lvl[ch]   <= 1'b0;
              fall[ch]  <= 1'b1;
            end else begin
              cnt[ch] <= cnt[ch] + 1'b1;
            end
          end
          default: begin
            state[ch] <= ST_LO;
            cnt[ch]   <= '0;
          end
        endcase
      end
    end
  end

  // Settle count: run length of cycles spent in a stable state.
  // It saturates at DEBOUNCE_CYCLES and is never cleared after that point.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      stl_nxt[ch] = stl_cnt[ch];
      if (stl_cnt[ch] != DEB_FULL) begin
        if (state[ch] == ST_LO || state[ch] == ST_HI) stl_nxt[ch] = stl_cnt[ch] + 1'b1;
        else                                          stl_nxt[ch] = '0;
      end
    end
  end

  // Register settle counts. valid goes high in the cycle both channels settle and stays high.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      stl_cnt[0] <= '0;
      stl_cnt[1] <= '0;
      valid      <= 1'b0;
    end else begin
      stl_cnt[0] <= stl_nxt[0];
      stl_cnt[1] <= stl_nxt[1];
      if (stl_nxt[0] == DEB_FULL && stl_nxt[1] == DEB_FULL) valid <= 1'b1;
    end
  end

`ifdef SH_HOLDOFF_EN
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              sh_fall_now;

  assign sh_fall_now = (state[1] == PEND_LO) && !s2[1] && (cnt[1] == DEB_LAST);

  // Holdoff timer. It loads on the edge that drops SH and counts down to 0.
  // SH rises are blocked while the timer is non-zero.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset)                 hold_cnt <= '0;
    else if (sh_fall_now)      hold_cnt <= HOLD_LOAD;
    else if (hold_cnt != '0)   hold_cnt <= hold_cnt - 1'b1;
  end

  assign blk = {(hold_cnt != '0), 1'b0};
`else
  assign blk = 2'b00;
`endif

  assign SL      = lvl[0];
  assign SH      = lvl[1];
  assign SL_rise = rise[0];
  assign SH_rise = rise[1];
  assign SL_fall = fall[0];
  assign SH_fall = fall[1];

endmodule

// File: tb/tb_sensor_conditioner.sv
// Testbench for sensor_conditioner (DEBOUNCE_CYCLES=8, HOLDOFF_CYCLES=20).
// A run-length reference model predicts all outputs every cycle. The bench
// adds directed literal checks and randomized glitch/hold/reset stimulus.
module tb_sensor_conditioner;

  localparam int D      = 8;
  localparam int HO     = 20;
  localparam int CNT_W  = 4;
  localparam int HOLD_W = 5;
`ifdef SH_HOLDOFF_EN
  localparam int T6 = HO + D - 2;
`else
  localparam int T6 = 3 + D;
`endif

  logic Clk    = 1'b0;
  logic reset  = 1'b1;
  logic SL_raw = 1'b0;
  logic SH_raw = 1'b0;
  logic SL, SH, SL_rise, SL_fall, SH_rise, SH_fall, valid;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [6:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CNT_W),
    .HOLDOFF_CYCLES(HO),
    .HOLD_W(HOLD_W)
  ) dut (
    .Clk(Clk),
    .reset(reset),
    .SL_raw(SL_raw),
    .SH_raw(SH_raw),
    .SL(SL),
    .SH(SH),
    .SL_rise(SL_rise),
    .SL_fall(SL_fall),
    .SH_rise(SH_rise),
    .SH_fall(SH_fall),
    .valid(valid)
  );

  // ---------------- reference model ----------------
  // Each channel flips its output once its synchronised input has disagreed
  // with the output for D+1 consecutive edges. A channel is stable in a cycle
  // where no disagreement run is in progress.
  int   run [2];
  int   stl [2];
  bit   m_out [2];
  bit   m_s1 [2];
  bit   m_s2 [2];
  bit   m_rise [2];
  bit   m_fall [2];
  bit   m_valid;
  int   since_fall;

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      run[c] = 0; stl[c] = 0; m_out[c] = 0; m_s1[c] = 0; m_s2[c] = 0;
      m_rise[c] = 0; m_fall[c] = 0;
    end
    m_valid    = 0;
    since_fall = HO;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [1:0] raw_now;
    bit stable, blocked;
    raw_now = {SH_raw, SL_raw};
    if (since_fall < HO) since_fall++;
    for (int c = 0; c < 2; c++) begin
      stable  = (run[c] == 0);
      blocked = 0;
`ifdef SH_HOLDOFF_EN
      if (c == 1 && !m_out[c] && since_fall < HO) blocked = 1;
`endif
      m_rise[c] = 0;
      m_fall[c] = 0;
      if (m_s2[c] != m_out[c] && !blocked) run[c]++;
      else run[c] = 0;
      if (run[c] == D + 1) begin
        m_out[c] = ~m_out[c];
        run[c]   = 0;
        if (m_out[c]) m_rise[c] = 1;
        else begin
          m_fall[c] = 1;
          if (c == 1) since_fall = 0;
        end
      end
      if (stable) begin
        if (stl[c] < D) stl[c]++;
      end else if (stl[c] < D) begin
        stl[c] = 0;
      end
    end
    if (stl[0] == D && stl[1] == D) m_valid = 1;
    for (int c = 0; c < 2; c++) begin
      m_s2[c] = m_s1[c];
      m_s1[c] = raw_now[c];
    end
    exp_q.push_back({m_valid, m_fall[1], m_rise[1], m_fall[0], m_rise[0], m_out[1], m_out[0]});
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge Clk or posedge reset);
      if (reset) model_clear();
      else       model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] outs();
    return {valid, SH_fall, SH_rise, SL_fall, SL_rise, SH, SL};
  endfunction

  initial begin
    logic [6:0] e;
    forever begin
      @(negedge Clk);
      if (reset) check("reset_outputs", 32'(outs()), 32'd0);
      else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("model_cycle", 32'(outs()), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic sample();
    @(negedge Clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500_000;
    n_fail++;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    // 1: reset for 3 cycles, then valid rises on the 8th edge after release
    wait_edges(3);
    reset = 1'b0;
    sample(); check("post_reset_outputs", 32'(outs()), 32'd0);
    wait_edges(7);
    sample(); check("valid_before_8", 32'(valid), 32'd0);
    wait_edges(1);
    sample(); check("valid_at_8", 32'(valid), 32'd1);

    // 2: SL rises 10 edges after the first sampling edge
    SL_raw = 1'b1;
    wait_edges(10);
    sample(); check("sl_before_10", 32'({SL, SL_rise}), 32'd0);
    wait_edges(1);
    sample(); check("sl_rise_at_10", 32'({SL, SL_rise, SL_fall}), 32'b110);
    wait_edges(1);
    sample(); check("sl_rise_one_cycle", 32'({SL, SL_rise}), 32'b10);

    // 3: a 5-cycle SH glitch is rejected
    SH_raw = 1'b1;
    wait_edges(5);
    SH_raw = 1'b0;
    wait_edges(15);
    sample(); check("sh_glitch_rejected", 32'({SH, SH_rise, SH_fall}), 32'd0);

    // 4: simultaneous rises pulse in the same cycle
    SL_raw = 1'b0;
    wait_edges(12);
    sample(); check("sl_back_low", 32'(SL), 32'd0);
    SL_raw = 1'b1;
    SH_raw = 1'b1;
    wait_edges(11);
    sample(); check("dual_rise", 32'({SL_rise, SH_rise, SL, SH}), 32'b1111);

    // 5: reset during SH pending discards it; SH then qualifies after release
    SL_raw = 1'b0;
    SH_raw = 1'b0;
    wait_edges(12);
    sample(); check("both_low", 32'({SL, SH}), 32'd0);
    SH_raw = 1'b1;
    wait_edges(6);
    reset = 1'b1;
    sample(); check("reset_mid_pend", 32'({SH, SH_rise}), 32'd0);
    wait_edges(2);
    reset = 1'b0;
    wait_edges(10);
    sample(); check("sh_before_10_after_reset", 32'(SH), 32'd0);
    wait_edges(1);
    sample(); check("sh_rise_after_reset", 32'({SH, SH_rise}), 32'b11);

    // 6: SH falls, then SH_raw returns 2 cycles later (holdoff when enabled)
    SH_raw = 1'b0;
    wait_edges(11);
    sample(); check("sh_fall", 32'({SH, SH_fall}), 32'b01);
    wait_edges(2);
    SH_raw = 1'b1;
    wait_edges(T6 - 1);
    sample(); check("sh_before_rerise", 32'(SH), 32'd0);
    wait_edges(1);
    sample(); check("sh_rerise", 32'({SH, SH_rise}), 32'b11);

    // randomized glitches, long holds and occasional resets
    for (int i = 0; i < 160; i++) begin
      int mode;
      mode = $urandom_range(0, 11);
      if (mode == 0) begin
        reset = 1'b1;
        wait_edges($urandom_range(1, 3));
        reset = 1'b0;
      end else begin
        if ($urandom_range(0, 1) == 1) SL_raw = ~SL_raw;
        if ($urandom_range(0, 1) == 1) SH_raw = ~SH_raw;
        if (mode < 5) wait_edges($urandom_range(1, D + 1));
        else          wait_edges($urandom_range(D, 3 * D + 4));
      end
    end
    SL_raw = 1'b0;
    SH_raw = 1'b0;
    wait_edges(HO + 3 * D);
    sample();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
